sync_fifo: RTL and testbench

Single-clock parametrised FIFO: the next generation of the team's fifomem storage block, with storage and control merged into one module. It adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is used wherever producer and consumer share one clock domain, in place of the asynchronous FIFO.

---
 rtl/sync_fifo_if.sv | 31 +++
 rtl/sync_fifo.sv | 106 ++++++++++
 tb/tb_sync_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: write side, read side and status outputs.
// The slave modport is the FIFO itself; the master modport is its user.
interface sync_fifo_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wr_data;
    logic             wr_en;
    logic             o_wfull;
    logic             o_walmost_full;
    logic             rd_en;
    logic [DSIZE-1:0] rd_data;
    logic             rd_valid;
    logic             o_rempty;
    logic             o_ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  wr_data, wr_en, rd_en,
        output o_wfull, o_walmost_full, rd_data, rd_valid,
               o_rempty, o_ralmost_empty, count, overflow, underflow
    );

    modport master (
        output wr_data, wr_en, rd_en,
        input  o_wfull, o_walmost_full, rd_data, rd_valid,
               o_rempty, o_ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and a registered or fall-through read port.
module sync_fifo #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input logic         clk,
    input logic         rst,
    sync_fifo_if.slave  bus
);
    localparam int              DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0]  C_DEPTH   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0]  C_AFULL   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0]  C_AEMPTY  = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0]  C_CNT_ONE = (ASIZE+1)'(1);
    localparam logic [ASIZE-1:0] C_PTR_ONE = ASIZE'(1);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_wr_ptr;
    logic [ASIZE-1:0] r_rd_ptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Full/empty come from the count so the pointers can wrap freely.
    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = bus.wr_en && !w_full;
    assign w_rd_acc = bus.rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_count <= r_count - C_CNT_ONE;
            end
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DSIZE-1:0] r_rd_data;
            logic             r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign bus.rd_data  = r_rd_data;
            assign bus.rd_valid = r_rd_valid;
        end else begin : g_fwft
            // Head word is always presented; zero when nothing is stored.
            assign bus.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
            assign bus.rd_valid = !w_empty;
        end
    endgenerate

    assign bus.o_wfull         = w_full;
    assign bus.o_walmost_full  = (r_count >= C_AFULL);
    assign bus.o_rempty        = w_empty;
    assign bus.o_ralmost_empty = (r_count <= C_AEMPTY);
    assign bus.count           = r_count;
    assign bus.overflow        = r_overflow;
    assign bus.underflow       = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: FIFO instance A in registered-read mode, instance B in
// fall-through mode, sharing clock and reset.
module tb_sync_fifo;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    sync_fifo_if #(.DSIZE(8), .ASIZE(4)) ifa ();
    sync_fifo_if #(.DSIZE(8), .ASIZE(4)) ifb ();

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int wr;
        int rd;
        int din;
        int cnt;
        int vld;
        int dat;
        int ovf;
        int udf;
    } vec_t;

    vec_t tbl [35];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int cnt, input int vld, input int dat,
                         input int ovf, input int udf);
        chk({tag, " A.count"},   32'(ifa.count),           32'(cnt));
        chk({tag, " A.full"},    32'(ifa.o_wfull),         (cnt == 16) ? 32'd1 : 32'd0);
        chk({tag, " A.afull"},   32'(ifa.o_walmost_full),  (cnt >= 12) ? 32'd1 : 32'd0);
        chk({tag, " A.empty"},   32'(ifa.o_rempty),        (cnt == 0)  ? 32'd1 : 32'd0);
        chk({tag, " A.aempty"},  32'(ifa.o_ralmost_empty), (cnt <= 2)  ? 32'd1 : 32'd0);
        chk({tag, " A.valid"},   32'(ifa.rd_valid),        32'(vld));
        chk({tag, " A.data"},    32'(ifa.rd_data),         32'(dat));
        chk({tag, " A.ovf"},     32'(ifa.overflow),        32'(ovf));
        chk({tag, " A.udf"},     32'(ifa.underflow),       32'(udf));
    endtask

    task automatic chk_b(input string tag, input int cnt, input int dat, input int udf);
        chk({tag, " B.count"},   32'(ifb.count),    32'(cnt));
        chk({tag, " B.empty"},   32'(ifb.o_rempty), (cnt == 0) ? 32'd1 : 32'd0);
        chk({tag, " B.valid"},   32'(ifb.rd_valid), (cnt != 0) ? 32'd1 : 32'd0);
        if (cnt != 0) begin
            chk({tag, " B.data"}, 32'(ifb.rd_data), 32'(dat));
        end
        chk({tag, " B.udf"},     32'(ifb.underflow), 32'(udf));
        chk({tag, " B.ovf"},     32'(ifb.overflow),  32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.wr_data = 8'h00;
        ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.wr_data = 8'h00;

        // Fill: 16 writes, one rejected write while full, 16 reads, idle, read while empty.
        for (int i = 0; i < 16; i++) tbl[i] = '{1, 0, i + 1, i + 1, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 'hAA, 16, 0, 0, 1, 0};
        for (int i = 0; i < 16; i++) tbl[17 + i] = '{0, 1, 0, 15 - i, 1, i + 1, 1, 0};
        tbl[33] = '{0, 0, 0, 0, 0, 'h10, 1, 0};
        tbl[34] = '{0, 1, 0, 0, 0, 'h10, 1, 1};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_a("reset", 0, 0, 0, 0, 0);
        chk_b("reset", 0, 0, 0);

        for (int i = 0; i < 35; i++) begin
            ifa.wr_en   = tbl[i].wr[0];
            ifa.rd_en   = tbl[i].rd[0];
            ifa.wr_data = tbl[i].din[7:0];
            tick();
            chk_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].vld, tbl[i].dat, tbl[i].ovf, tbl[i].udf);
        end
        ifa.wr_en = 1'b0;
        ifa.rd_en = 1'b0;

        // Hold count at 5 with simultaneous read/write across the pointer wrap.
        for (int k = 0; k < 5; k++) begin
            ifa.wr_en = 1'b1; ifa.wr_data = 8'(8'h20 + k);
            tick();
        end
        chk_a("prefill", 5, 0, 'h10, 1, 1);
        for (int k = 0; k < 40; k++) begin
            ifa.wr_en = 1'b1; ifa.rd_en = 1'b1; ifa.wr_data = 8'(8'h25 + k);
            tick();
            chk_a($sformatf("simul%0d", k), 5, 1, 'h20 + k, 1, 1);
        end
        ifa.wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ifa.rd_en = 1'b1;
            tick();
            chk_a($sformatf("drain%0d", k), 4 - k, 1, 'h48 + k, 1, 1);
        end
        ifa.rd_en = 1'b0;

        // Fall-through: first word visible without rd_en, popped by rd_en.
        ifb.wr_en = 1'b1; ifb.wr_data = 8'h5A;
        tick();
        ifb.wr_en = 1'b0;
        chk_b("fwft_wr", 1, 'h5A, 0);
        tick();
        chk_b("fwft_hold", 1, 'h5A, 0);
        ifb.rd_en = 1'b1;
        tick();
        ifb.rd_en = 1'b0;
        chk_b("fwft_pop", 0, 0, 0);
        ifb.wr_en = 1'b1; ifb.wr_data = 8'h11;
        tick();
        ifb.wr_data = 8'h22;
        tick();
        ifb.wr_en = 1'b0;
        chk_b("fwft_two", 2, 'h11, 0);
        ifb.rd_en = 1'b1;
        tick();
        chk_b("fwft_next", 1, 'h22, 0);
        tick();
        chk_b("fwft_last", 0, 0, 0);
        // Read+write on empty: read rejected (underflow), write accepted.
        ifb.wr_en = 1'b1; ifb.wr_data = 8'h77;
        tick();
        ifb.wr_en = 1'b0; ifb.rd_en = 1'b0;
        chk_b("fwft_rw_empty", 1, 'h77, 1);

        // Asynchronous reset in the middle of a pending read with 9 words stored.
        for (int k = 0; k < 9; k++) begin
            ifa.wr_en = 1'b1; ifa.wr_data = 8'(8'h60 + k);
            tick();
        end
        ifa.wr_en = 1'b0;
        chk_a("pre_rst", 9, 0, 'h4C, 1, 1);
        ifa.rd_en = 1'b1;
        tick();
        chk_a("rd_inflight", 8, 1, 'h60, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_a("async_rst", 0, 0, 0, 0, 0);
        chk_b("async_rst", 0, 0, 0);
        ifa.rd_en = 1'b0;
        tick();
        rst = 1'b0;
        ifa.wr_en = 1'b1; ifa.wr_data = 8'h33;
        tick();
        ifa.wr_en = 1'b0;
        chk_a("post_rst_wr", 1, 0, 0, 0, 0);
        ifa.rd_en = 1'b1;
        tick();
        ifa.rd_en = 1'b0;
        chk_a("post_rst_rd", 0, 1, 'h33, 0, 0);
        tick();
        chk_a("post_rst_idle", 0, 0, 'h33, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
